// File: rtl/obi_pinser_pkg.sv
// Shared types and helpers for the OBI pin serializer.
package obi_pinser_pkg;

  // Protocol phases; busy whenever not IDLE.
  typedef enum logic [2:0] {
    IDLE,
    TX_HDR,
    TX_ADDR,
    TX_DATA,
    RX_STAT,
    RX_DATA,
    RESP
  } state_e;

  // Header word layout: {be, we}, LSB first on the pad bus.
  localparam int WeBit = 0;
  localparam int BeLsb = 1;

  // Integer ceiling division used to size each frame field in beats.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/obi_pinser_shift.sv
// Parallel-load shift register stepping Step bits per shift toward the LSB.
// New bits enter at the MSB end, so the first beat shifted in ends up lowest.
module obi_pinser_shift #(
  parameter int W    = 32,
  parameter int Step = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic [W-1:0]    load_data_i,
  input  logic            shift_i,
  input  logic [Step-1:0] shift_in_i,
  output logic [W-1:0]    data_o
);

  logic [W-1:0] data_q;

  // Shift/load register: clear beats load beats shift.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written with <= only, so every register in
    // this block samples its inputs from the same clock edge.
    if (rst_i || clr_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= {shift_in_i, data_q[W-1:Step]};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/obi_pin_serializer.sv
// Bridges a full-width OBI port onto a narrow pad bus: one request in flight,
// request sent as {header, address, [wdata]} beats, response collected as
// {status, [rdata]} beats.
// Optional build macro OBI_PINSER_TIMEOUT_EN adds a response timeout that
// completes the transaction with err_o = 1 and rdata_o = 0.
module obi_pin_serializer
  import obi_pinser_pkg::*;
#(
  parameter int AddrW         = 32,
  parameter int DataW         = 32,
  parameter int PinW          = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic               we_i,
  input  logic [DataW/8-1:0] be_i,
  input  logic [AddrW-1:0]   addr_i,
  input  logic [DataW-1:0]   wdata_i,
  output logic               rvalid_o,
  output logic [DataW-1:0]   rdata_o,
  output logic               err_o,
  output logic [PinW-1:0]    pin_tx_o,
  output logic               pin_tx_valid_o,
  input  logic [PinW-1:0]    pin_rx_i,
  input  logic               pin_rx_valid_i,
  output logic               busy_o
);

  localparam int BeW       = DataW / 8;
  localparam int HdrBeats  = ceil_div(1 + BeW, PinW);
  localparam int AddrBeats = ceil_div(AddrW, PinW);
  localparam int DataBeats = DataW / PinW;
  localparam int HdrW      = HdrBeats * PinW;
  localparam int AddrPadW  = AddrBeats * PinW;
  localparam int TxW       = HdrW + AddrPadW + DataW;
  localparam int MaxBeats  = (AddrBeats > DataBeats) ?
                             ((AddrBeats > HdrBeats) ? AddrBeats : HdrBeats) :
                             ((DataBeats > HdrBeats) ? DataBeats : HdrBeats);
  localparam int CntW      = $clog2(MaxBeats + 1);

  localparam logic [CntW-1:0] HdrLast  = CntW'(HdrBeats - 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(AddrBeats - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DataBeats - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q;
  logic            err_q, err_d;
  logic            tx_load, tx_shift, tx_active;
  logic            rx_clr, rx_shift;
  logic [TxW-1:0]  frame;
  logic [TxW-1:0]  tx_data;
  logic [DataW-1:0] rx_data;
  logic            tx_unused;

  // Assemble the whole outbound frame so it can be loaded in one go.
  always_comb begin
    frame                        = '0;
    frame[WeBit]                 = we_i;
    frame[BeLsb +: BeW]          = be_i;
    frame[HdrW +: AddrW]         = addr_i;
    frame[HdrW + AddrPadW +: DataW] = wdata_i;
  end

  obi_pinser_shift #(.W(TxW), .Step(PinW)) u_tx_shift (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (1'b0),
    .load_i      (tx_load),
    .load_data_i (frame),
    .shift_i     (tx_shift),
    .shift_in_i  ('0),
    .data_o      (tx_data)
  );

  obi_pinser_shift #(.W(DataW), .Step(PinW)) u_rx_shift (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (rx_clr),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (rx_shift),
    .shift_in_i  (pin_rx_i),
    .data_o      (rx_data)
  );

  // Only the low beat of the tx register is ever driven onto the pads.
  assign tx_unused = ^tx_data[TxW-1:PinW];

`ifdef OBI_PINSER_TIMEOUT_EN
  localparam int ToW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  logic [ToW-1:0] to_q;
  logic           rx_wait;
  logic           timeout_hit;

  assign rx_wait = (state_q == RX_STAT) || (state_q == RX_DATA);

  // Idle-cycle counter for the response phase; any rx beat restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i || !rx_wait || pin_rx_valid_i) begin
      to_q <= '0;
    end else begin
      to_q <= to_q + ToW'(1);
    end
  end

  // Fires in the cycle the count advances to TimeoutCycles-1, which places
  // RESP exactly TimeoutCycles cycles after the last tx beat.
  assign timeout_hit = rx_wait && !pin_rx_valid_i &&
                       (to_q == ToW'(TimeoutCycles - 2));
`endif

  // Next-state and datapath control for the frame sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    rx_clr   = 1'b0;
    rx_shift = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          tx_load = 1'b1;
          rx_clr  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = TX_HDR;
        end
      end
      TX_HDR: begin
        tx_shift = 1'b1;
        if (cnt_q == HdrLast) begin
          cnt_d   = '0;
          state_d = TX_ADDR;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      TX_ADDR: begin
        tx_shift = 1'b1;
        if (cnt_q == AddrLast) begin
          cnt_d   = '0;
          state_d = we_q ? TX_DATA : RX_STAT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      TX_DATA: begin
        tx_shift = 1'b1;
        if (cnt_q == DataLast) begin
          cnt_d   = '0;
          state_d = RX_STAT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_STAT: begin
        if (pin_rx_valid_i) begin
          err_d   = pin_rx_i[0];
          state_d = we_q ? RESP : RX_DATA;
        end
      end
      RX_DATA: begin
        if (pin_rx_valid_i) begin
          rx_shift = 1'b1;
          if (cnt_q == DataLast) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef OBI_PINSER_TIMEOUT_EN
    if (timeout_hit) begin
      err_d   = 1'b1;
      rx_clr  = 1'b1;
      cnt_d   = '0;
      state_d = RESP;
    end
`endif
  end

  // State, beat counter and captured transaction attributes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (tx_load) begin
        we_q <= we_i;
      end
    end
  end

  assign tx_active      = (state_q == TX_HDR) || (state_q == TX_ADDR) ||
                          (state_q == TX_DATA);
  assign pin_tx_valid_o = tx_active;
  assign pin_tx_o       = tx_active ? tx_data[PinW-1:0] : '0;
  assign gnt_o          = (state_q == IDLE) && req_i;
  assign busy_o         = (state_q != IDLE);
  assign rvalid_o       = (state_q == RESP);
  assign rdata_o        = rx_data;
  assign err_o          = err_q;

endmodule

// File: tb/tb_obi_pin_serializer.sv
// Directed bench for obi_pin_serializer: default 4-bit pad bus plus a 16-bit
// instance. The timeout scenario runs only when OBI_PINSER_TIMEOUT_EN is set.
module tb_obi_pin_serializer;

  logic        clk;
  logic        rst_i;
  logic        req_i, gnt_o, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        rvalid_o, err_o, busy_o;
  logic [3:0]  pin_tx_o, pin_rx_i;
  logic        pin_tx_valid_o, pin_rx_valid_i;

  logic        req16, gnt16, we16, rvalid16, err16, busy16, txv16, rxv16;
  logic [3:0]  be16;
  logic [31:0] addr16, wdata16, rdata16;
  logic [15:0] tx16, rx16;

  int n_checks = 0;
  int n_bad    = 0;

  logic [3:0] exp_tx [32];
  int         n_tx;
  logic [3:0] rx_seq [32];
  int         n_rx;

  obi_pin_serializer #(.AddrW(32), .DataW(32), .PinW(4), .TimeoutCycles(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .pin_tx_o(pin_tx_o),
    .pin_tx_valid_o(pin_tx_valid_o), .pin_rx_i(pin_rx_i),
    .pin_rx_valid_i(pin_rx_valid_i), .busy_o(busy_o)
  );

  obi_pin_serializer #(.AddrW(32), .DataW(32), .PinW(16), .TimeoutCycles(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req16), .gnt_o(gnt16), .we_i(we16),
    .be_i(be16), .addr_i(addr16), .wdata_i(wdata16), .rvalid_o(rvalid16),
    .rdata_o(rdata16), .err_o(err16), .pin_tx_o(tx16),
    .pin_tx_valid_o(txv16), .pin_rx_i(rx16),
    .pin_rx_valid_i(rxv16), .busy_o(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unpack hand-written beat lists; beat 0 is the lowest nibble.
  task automatic load_tx(input logic [127:0] nibbles, input int n);
    for (int i = 0; i < n; i++) exp_tx[i] = nibbles[i*4 +: 4];
    n_tx = n;
  endtask

  task automatic load_rx(input logic [127:0] nibbles, input int n);
    for (int i = 0; i < n; i++) rx_seq[i] = nibbles[i*4 +: 4];
    n_rx = n;
  endtask

  // One full transaction on the 4-bit instance against exp_tx / rx_seq.
  task automatic run_txn(input string name, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int gap, input logic hold_req, input logic rx_noise,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int   waited;
    logic saw_gnt;
    logic early_rvalid;
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
    waited = 0;
    #1;
    while (!gnt_o && waited < 64) begin
      tick();
      waited++;
      #1;
    end
    check({name, ":gnt"}, 64'(gnt_o), 64'(1));
    tick();
    if (!hold_req) req_i = 1'b0;
    saw_gnt = 1'b0;
    early_rvalid = 1'b0;
    for (int i = 0; i < n_tx; i++) begin
      if (rx_noise) begin
        pin_rx_valid_i = 1'b1;
        pin_rx_i = 4'hF;
      end
      #1;
      check($sformatf("%s:tx%0d", name, i), 64'({pin_tx_valid_o, pin_tx_o}),
            64'({1'b1, exp_tx[i]}));
      saw_gnt |= gnt_o;
      tick();
    end
    pin_rx_valid_i = 1'b0;
    pin_rx_i = 4'h0;
    #1;
    check({name, ":tx_quiet"}, 64'({busy_o, pin_tx_valid_o, pin_tx_o}), 64'({1'b1, 1'b0, 4'h0}));
    for (int b = 0; b < n_rx; b++) begin
      for (int g = 0; g < gap; g++) begin
        pin_rx_valid_i = 1'b0;
        pin_rx_i = 4'h7;
        #1;
        saw_gnt |= gnt_o;
        early_rvalid |= rvalid_o;
        tick();
      end
      pin_rx_valid_i = 1'b1;
      pin_rx_i = rx_seq[b];
      #1;
      saw_gnt |= gnt_o;
      early_rvalid |= rvalid_o;
      tick();
    end
    pin_rx_valid_i = 1'b0;
    pin_rx_i = 4'h0;
    #1;
    saw_gnt |= gnt_o;
    check({name, ":no_early_rvalid"}, 64'(early_rvalid), 64'(0));
    check({name, ":rvalid"}, 64'(rvalid_o), 64'(1));
    check({name, ":rdata"}, 64'(rdata_o), 64'(exp_rdata));
    check({name, ":err"}, 64'(err_o), 64'(exp_err));
    if (hold_req) check({name, ":no_gnt_while_busy"}, 64'(saw_gnt), 64'(0));
    tick();
    #1;
    check({name, ":idle"}, 64'({rvalid_o, busy_o}), 64'(0));
    if (hold_req) begin
      check({name, ":gnt_after_resp"}, 64'(gnt_o), 64'(1));
      req_i = 1'b0;
    end
  endtask

  initial begin
    int   k;
    logic bad_seen;
    logic [15:0] exp16 [3];
    logic [15:0] rsp16 [3];

    rst_i = 1'b1;
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    pin_rx_i = 4'h0; pin_rx_valid_i = 1'b0;
    req16 = 1'b0; we16 = 1'b0; be16 = 4'h0; addr16 = '0; wdata16 = '0;
    rx16 = '0; rxv16 = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check("reset:outs", 64'({gnt_o, rvalid_o, err_o, pin_tx_valid_o, pin_tx_o, busy_o}), 64'(0));
    check("reset:rdata", 64'(rdata_o), 64'(0));
    check("reset:outs16", 64'({gnt16, rvalid16, err16, txv16, tx16, busy16, rdata16}), 64'(0));

    // Read 0x1234: header {be=F,we=0}=0x1E, then address nibbles.
    load_tx(128'h0000_1234_1E, 10);
    load_rx(128'hCBA9_8765_0, 9);
    run_txn("read", 1'b0, 4'hF, 32'h0000_1234, 32'h0, 0, 1'b0, 1'b0, 32'hCBA9_8765, 1'b0);

    // Write: header 0x1F, address 0x40, data DEADBEEF; stray rx beats during tx.
    load_tx(128'hDEAD_BEEF_0000_0040_1F, 18);
    load_rx(128'h1, 1);
    run_txn("write", 1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 32'h0, 1'b1);

    // Same read with 3-cycle gaps and req_i held throughout.
    load_tx(128'h0000_1234_1E, 10);
    load_rx(128'hCBA9_8765_0, 9);
    run_txn("read_gap", 1'b0, 4'hF, 32'h0000_1234, 32'h0, 3, 1'b1, 1'b0, 32'hCBA9_8765, 1'b0);

    // Reset while in TX_ADDR.
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0000_1234;
    #1;
    check("rst_mid:gnt", 64'(gnt_o), 64'(1));
    tick();
    req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tick();
    end
    #1;
    check("rst_mid:in_tx", 64'({busy_o, pin_tx_valid_o}), 64'({1'b1, 1'b1}));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("rst_mid:after", 64'({busy_o, pin_tx_valid_o, pin_tx_o, rvalid_o}), 64'(0));
    bad_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pin_rx_valid_i = 1'b1;
      pin_rx_i = 4'h1;
      #1;
      bad_seen |= rvalid_o | busy_o;
      tick();
    end
    pin_rx_valid_i = 1'b0;
    pin_rx_i = 4'h0;
    check("rst_mid:quiet", 64'(bad_seen), 64'(0));
    load_tx(128'h0000_1234_1E, 10);
    load_rx(128'h1234_5678_0, 9);
    run_txn("read_post_rst", 1'b0, 4'hF, 32'h0000_1234, 32'h0, 0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);

    // 16-bit pad bus: 1 header + 2 address beats, 1 status + 2 data beats.
    exp16[0] = 16'h001E; exp16[1] = 16'h5678; exp16[2] = 16'h1234;
    rsp16[0] = 16'h0000; rsp16[1] = 16'hBEEF; rsp16[2] = 16'hCAFE;
    req16 = 1'b1; we16 = 1'b0; be16 = 4'hF; addr16 = 32'h1234_5678;
    #1;
    check("p16:gnt", 64'(gnt16), 64'(1));
    tick();
    req16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("p16:tx%0d", i), 64'({txv16, tx16}), 64'({1'b1, exp16[i]}));
      tick();
    end
    #1;
    check("p16:tx_quiet", 64'({txv16, tx16}), 64'(0));
    for (int i = 0; i < 3; i++) begin
      rxv16 = 1'b1;
      rx16 = rsp16[i];
      tick();
    end
    rxv16 = 1'b0;
    rx16 = '0;
    #1;
    check("p16:resp", 64'({rvalid16, err16, rdata16}), 64'({1'b1, 1'b0, 32'hCAFE_BEEF}));

`ifdef OBI_PINSER_TIMEOUT_EN
    // No response at all: RESP 16 cycles after the last tx beat.
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0000_1234;
    #1;
    check("to:gnt", 64'(gnt_o), 64'(1));
    tick();
    req_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      tick();
    end
    k = 1;
    #1;
    while (!rvalid_o && k < 40) begin
      tick();
      k++;
      #1;
    end
    check("to:latency", 64'(k), 64'(16));
    check("to:resp", 64'({rvalid_o, err_o, rdata_o}), 64'({1'b1, 1'b1, 32'h0}));
    tick();
    pin_rx_valid_i = 1'b1;
    pin_rx_i = 4'h0;
    #1;
    check("to:idle", 64'(busy_o), 64'(0));
    tick();
    pin_rx_valid_i = 1'b0;
    #1;
    check("to:late_ignored", 64'({busy_o, rvalid_o}), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
